// File: rtl/alu.sv
// 16-bit execute-stage ALU with saturating adder and the architectural Z/V/N flag register.
// Optional build macro ALU_PADDSB_EN turns opcode 7 into PADDSB (four 4-bit signed saturating adds).
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ALU_In1,
   input  logic [15:0] ALU_In2,
   input  logic [3:0]  Opcode,
   output logic [15:0] ALU_Out,
   output logic        Ovfl,
   output logic        Neg,
   output logic        Zero,
   output logic        Flag_Write,
   output logic        flag_z,
   output logic        flag_v,
   output logic        flag_n
);

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_XOR    = 4'h2,
      OP_RED    = 4'h3,
      OP_SLL    = 4'h4,
      OP_SRA    = 4'h5,
      OP_ROR    = 4'h6,
      OP_PADDSB = 4'h7,
      OP_LW     = 4'h8,
      OP_SW     = 4'h9,
      OP_LLB    = 4'hA,
      OP_LHB    = 4'hB
   } opcode_e;

   opcode_e     op;
   logic [3:0]  shamt;
   logic        is_sub;
   logic [15:0] add_b;
   logic [15:0] add_raw;
   logic        add_ovfl;
   logic [15:0] add_sat;
   logic [15:0] ror_out;

   assign op    = opcode_e'(Opcode);
   assign shamt = ALU_In2[3:0];

   // One shared adder serves ADD/SUB/LW/SW; SUB adds ~B + 1.
   assign is_sub   = (op == OP_SUB);
   assign add_b    = is_sub ? ~ALU_In2 : ALU_In2;
   assign add_raw  = ALU_In1 + add_b + {15'b0, is_sub};
   assign add_ovfl = (ALU_In1[15] == add_b[15]) && (add_raw[15] != ALU_In1[15]);
   assign add_sat  = add_ovfl ? (ALU_In1[15] ? 16'h8000 : 16'h7FFF) : add_raw;

   // A 16-bit value shifted left by 16 is all zeros, so amount 0 leaves A unchanged.
   assign ror_out = (ALU_In1 >> shamt) | (ALU_In1 << (5'd16 - {1'b0, shamt}));

   // RED: the final sum needs 7 bits (range -64..+56) before sign extension.
   logic [3:0][4:0] red_s;
   logic [5:0]      red_hi;
   logic [5:0]      red_lo;
   logic [6:0]      red_sum;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         red_s[i] = {ALU_In1[4*i+3], ALU_In1[4*i +: 4]} + {ALU_In2[4*i+3], ALU_In2[4*i +: 4]};
      end
      red_hi  = {red_s[3][4], red_s[3]} + {red_s[2][4], red_s[2]};
      red_lo  = {red_s[1][4], red_s[1]} + {red_s[0][4], red_s[0]};
      red_sum = {red_hi[5], red_hi} + {red_lo[5], red_lo};
   end

`ifdef ALU_PADDSB_EN
   logic [3:0][3:0] pad_raw;
   logic [15:0]     pad_out;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pad_raw[i] = ALU_In1[4*i +: 4] + ALU_In2[4*i +: 4];
         if ((ALU_In1[4*i+3] == ALU_In2[4*i+3]) && (pad_raw[i][3] != ALU_In1[4*i+3])) begin
            pad_out[4*i +: 4] = ALU_In1[4*i+3] ? 4'h8 : 4'h7;
         end else begin
            pad_out[4*i +: 4] = pad_raw[i];
         end
      end
   end
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      ALU_Out    = 16'h0000;
      Ovfl       = 1'b0;
      Flag_Write = 1'b0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            ALU_Out    = add_sat;
            Ovfl       = add_ovfl;
            Flag_Write = 1'b1;
         end
         OP_LW, OP_SW: begin
            ALU_Out = add_sat;
            Ovfl    = add_ovfl;
         end
         OP_XOR: begin
            ALU_Out    = ALU_In1 ^ ALU_In2;
            Flag_Write = 1'b1;
         end
         OP_SLL: begin
            ALU_Out    = ALU_In1 << shamt;
            Flag_Write = 1'b1;
         end
         OP_SRA: begin
            ALU_Out    = $unsigned($signed(ALU_In1) >>> shamt);
            Flag_Write = 1'b1;
         end
         OP_ROR: begin
            ALU_Out    = ror_out;
            Flag_Write = 1'b1;
         end
         OP_RED:    ALU_Out = {{9{red_sum[6]}}, red_sum};
         OP_LLB:    ALU_Out = {ALU_In1[15:8], ALU_In2[7:0]};
         OP_LHB:    ALU_Out = {ALU_In2[15:8], ALU_In1[7:0]};
`ifdef ALU_PADDSB_EN
         OP_PADDSB: ALU_Out = pad_out;
`endif
         default: ALU_Out = 16'h0000;
      endcase
   end

   assign Neg  = ALU_Out[15];
   assign Zero = (ALU_Out == 16'h0000);

   // Logic ops touch only Z; the arithmetic ops own V and N as well.
   logic flag_z_d, flag_v_d, flag_n_d;
   logic flag_z_q, flag_v_q, flag_n_q;

   always_comb begin
      flag_z_d = flag_z_q;
      flag_v_d = flag_v_q;
      flag_n_d = flag_n_q;
      if (Flag_Write) begin
         flag_z_d = Zero;
         if ((op == OP_ADD) || (op == OP_SUB)) begin
            flag_v_d = Ovfl;
            flag_n_d = Neg;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z_q <= 1'b0;
         flag_v_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         flag_z_q <= flag_z_d;
         flag_v_q <= flag_v_d;
         flag_n_q <= flag_n_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_v = flag_v_q;
   assign flag_n = flag_n_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed and random ops, expected results queued at drive time
// and compared once the combinational outputs settle; flag register checked between edges.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [15:0] in1;
   logic [15:0] in2;
   logic [3:0]  opcode;
   logic [15:0] alu_out;
   logic        ovfl, neg, zero, flag_write;
   logic        flag_z, flag_v, flag_n;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ALU_In1    (in1),
      .ALU_In2    (in2),
      .Opcode     (opcode),
      .ALU_Out    (alu_out),
      .Ovfl       (ovfl),
      .Neg        (neg),
      .Zero       (zero),
      .Flag_Write (flag_write),
      .flag_z     (flag_z),
      .flag_v     (flag_v),
      .flag_n     (flag_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] out;
      logic        ovfl;
      logic        neg;
      logic        zero;
      logic        fw;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive one op on the falling edge, queue its expectation, compare after settling.
   task automatic apply(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] e_out, input logic e_ovfl,
                        input logic e_neg, input logic e_zero, input logic e_fw);
      exp_t e;
      @(negedge clk);
      opcode = op;
      in1    = a;
      in2    = b;
      e.tag = tag; e.out = e_out; e.ovfl = e_ovfl; e.neg = e_neg; e.zero = e_zero; e.fw = e_fw;
      exp_q.push_back(e);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, " out"},  alu_out,             e.out);
         check({e.tag, " ovfl"}, {15'b0, ovfl},       {15'b0, e.ovfl});
         check({e.tag, " neg"},  {15'b0, neg},        {15'b0, e.neg});
         check({e.tag, " zero"}, {15'b0, zero},       {15'b0, e.zero});
         check({e.tag, " fw"},   {15'b0, flag_write}, {15'b0, e.fw});
      end
   endtask

   task automatic check_flags(input string tag, input logic z, input logic v, input logic n);
      @(negedge clk);
      check({tag, " flag_z"}, {15'b0, flag_z}, {15'b0, z});
      check({tag, " flag_v"}, {15'b0, flag_v}, {15'b0, v});
      check({tag, " flag_n"}, {15'b0, flag_n}, {15'b0, n});
   endtask

   // Reference computed with 32-bit integer arithmetic then clamped.
   task automatic model_addsub(input logic [15:0] a, input logic [15:0] b, input bit sub,
                               output logic [15:0] r, output logic ov);
      int s;
      s  = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
      ov = (s > 32767) || (s < -32768);
      if (s > 32767)       r = 16'h7FFF;
      else if (s < -32768) r = 16'h8000;
      else                 r = s[15:0];
   endtask

   function automatic logic [15:0] model_ror(input logic [15:0] a, input logic [3:0] n);
      logic [15:0] r;
      r = a;
      for (int k = 0; k < int'(n); k++) r = {r[0], r[15:1]};
      return r;
   endfunction

   initial begin
      logic [15:0] a, b, r;
      logic        ov;
      logic [3:0]  n;
      bit          sub;

      rst_n  = 1'b0;
      in1    = 16'h0000;
      in2    = 16'h0000;
      opcode = 4'h0;
      #12;
      check("reset flag_z", {15'b0, flag_z}, 16'h0000);
      check("reset flag_v", {15'b0, flag_v}, 16'h0000);
      check("reset flag_n", {15'b0, flag_n}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      apply("add_pos_sat", 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1, 0, 0, 1);
      check_flags("add_pos_sat", 0, 1, 0);
      apply("add_neg_sat", 4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1, 1, 0, 1);
      check_flags("add_neg_sat", 0, 1, 1);
      apply("add_plain",   4'h0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 1);
      check_flags("add_plain", 0, 0, 0);
      apply("sub_neg_sat", 4'h1, 16'h8000, 16'h0001, 16'h8000, 1, 1, 0, 1);
      check_flags("sub_neg_sat", 0, 1, 1);
      apply("xor_zero",    4'h2, 16'h00FF, 16'h00FF, 16'h0000, 0, 0, 1, 1);
      check_flags("xor_z_only", 1, 1, 1);
      apply("sub_equal",   4'h1, 16'h1234, 16'h1234, 16'h0000, 0, 0, 1, 1);
      check_flags("sub_equal", 1, 0, 0);
      apply("sub_pos_sat", 4'h1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1, 0, 0, 1);
      apply("sll",         4'h4, 16'h8001, 16'h0001, 16'h0002, 0, 0, 0, 1);
      check_flags("sll_z_only", 0, 1, 0);
      apply("sra_fill",    4'h5, 16'h8000, 16'h000F, 16'hFFFF, 0, 1, 0, 1);
      apply("sra_pos",     4'h5, 16'h4000, 16'hFFF2, 16'h1000, 0, 0, 0, 1);
      apply("ror_1",       4'h6, 16'h0001, 16'h0001, 16'h8000, 0, 1, 0, 1);
      apply("ror_0",       4'h6, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 1);
      apply("xor_mix",     4'h2, 16'hA5A5, 16'h0FF0, 16'hAA55, 0, 1, 0, 1);

      apply("sub_set_z",   4'h1, 16'h0042, 16'h0042, 16'h0000, 0, 0, 1, 1);
      check_flags("sub_set_z", 1, 0, 0);
      apply("red_pos",     4'h3, 16'h7777, 16'h7777, 16'h0038, 0, 0, 0, 0);
      check_flags("red_hold", 1, 0, 0);
      apply("red_neg",     4'h3, 16'h8888, 16'h8888, 16'hFFC0, 0, 1, 0, 0);
      apply("llb",         4'hA, 16'h1234, 16'h00AB, 16'h12AB, 0, 0, 0, 0);
      apply("lhb",         4'hB, 16'h1234, 16'hAB00, 16'hAB34, 0, 1, 0, 0);
      apply("lw",          4'h8, 16'h0010, 16'h0004, 16'h0014, 0, 0, 0, 0);
      apply("sw_sat",      4'h9, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 0, 0, 0);
      check_flags("sw_hold", 1, 0, 0);
`ifdef ALU_PADDSB_EN
      apply("paddsb_pos",  4'h7, 16'h7777, 16'h1111, 16'h7777, 0, 0, 0, 0);
      apply("paddsb_neg",  4'h7, 16'h8888, 16'hFFFF, 16'h8888, 0, 1, 0, 0);
      apply("paddsb_mix",  4'h7, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0);
`else
      apply("op7_unused",  4'h7, 16'h7777, 16'h1111, 16'h0000, 0, 0, 1, 0);
`endif
      apply("opC_unused",  4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 1, 0);
      apply("opF_unused",  4'hF, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 1, 0);
      check_flags("unused_hold", 1, 0, 0);

      // Asynchronous reset between clock edges.
      apply("add_pre_rst", 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1, 0, 0, 1);
      check_flags("add_pre_rst", 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst flag_z", {15'b0, flag_z}, 16'h0000);
      check("async_rst flag_v", {15'b0, flag_v}, 16'h0000);
      check("async_rst flag_n", {15'b0, flag_n}, 16'h0000);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         a   = 16'($urandom());
         b   = 16'($urandom());
         sub = (i % 2) == 1;
         if (i % 6 == 0) b = a ^ 16'h8000;
         model_addsub(a, b, sub, r, ov);
         apply(sub ? "rnd_sub" : "rnd_add", sub ? 4'h1 : 4'h0, a, b, r, ov, r[15], r == 16'h0000, 1);
      end
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom());
         n = 4'($urandom_range(0, 15));
         r = model_ror(a, n);
         apply("rnd_ror", 4'h6, a, {12'h0, n}, r, 0, r[15], r == 16'h0000, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
